instr_fetch_unit: RTL and testbench

Sequential instruction-fetch front end for the MIPS core. It holds the PC and requests instruction words from instruction memory over a ready handshake. It presents opcode/funct to the control unit and takes back that unit's branch/jump decisions to compute the next PC. It is the producer side of the control unit's opcode/funct interface and the consumer of its branch/jump outputs.

---
 rtl/instr_fetch_unit_if.sv | 15 +
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit and instruction memory.
//   imemReq   : read request, held until imemReady
//   imemAddr  : word address being fetched (the fetch unit's pc)
//   imemReady : memory has imemData valid this cycle
//   imemData  : instruction word returned by memory
// master = fetch unit, slave = memory.
interface instr_fetch_unit_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;

  modport master (output imemReq, imemAddr, input  imemReady, imemData);
  modport slave  (input  imemReq, imemAddr, output imemReady, imemData);
endinterface

// File: rtl/instr_fetch_unit.sv
// Sequential MIPS instruction-fetch front end.
// Holds the pc, fetches one word at a time over the imem bus, presents the
// held word (opcode/funct slices) to the control unit and, when the datapath
// accepts it, advances pc using the control unit's branch/jump decisions.
// Ports:
//   clk, reset          : clock (rising edge), async active-high reset
//   imem (master)       : instruction-memory request/response bus
//   instr/opcode/funct  : held instruction word and its decode slices
//   instrValid          : held word valid for decode (HOLD state)
//   instrAccept         : datapath has executed the held instruction
//   branch/jump/zero    : control unit decisions and ALU zero flag
//   jrTarget            : rs value used as target by jr
//   halt                : stop fetching after the current instruction
//   pc/pcPlus4          : address of held/pending instruction and pc+4
//   instrCount          : number of accepted instructions (wraps)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master imem,
  output logic [31:0]        instr,
  output logic [5:0]         opcode,
  output logic [5:0]         funct,
  output logic               instrValid,
  input  logic               instrAccept,
  input  logic               branch,
  input  logic               jump,
  input  logic               zero,
  input  logic [31:0]        jrTarget,
  input  logic               halt,
  output logic [31:0]        pc,
  output logic [31:0]        pcPlus4,
  output logic [COUNT_W-1:0] instrCount
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [31:0] next_pc;
  logic [31:0] br_off;
  logic        is_jr, br_taken;
  logic        unused;

  // jr targets are word aligned; the low rs bits are dropped on purpose
  assign unused = ^jrTarget[1:0];

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!halt)            state_nxt = FETCH;
      FETCH:   if (imem.imemReady)   state_nxt = HOLD;
      HOLD:    if (instrAccept)      state_nxt = halt ? IDLE : FETCH;
      default:                       state_nxt = IDLE;
    endcase
  end

  // output logic: request and valid are mutually exclusive by state
  always_comb begin
    imem.imemReq  = (state == FETCH);
    imem.imemAddr = pc;
    instrValid    = (state == HOLD);
  end

  assign opcode  = instr[31:26];
  assign funct   = instr[5:0];
  assign pcPlus4 = pc + 32'd4;

  // next pc, priority jr > jump > taken branch > sequential
  assign is_jr    = (opcode == 6'd0) && (funct == 6'd8);
  assign br_taken = branch && (((opcode == 6'd4) && zero) || ((opcode == 6'd5) && !zero));
  assign br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    next_pc = pcPlus4;
    if (is_jr)         next_pc = {jrTarget[31:2], 2'b00};
    else if (jump)     next_pc = {pcPlus4[31:28], instr[25:0], 2'b00};
    else if (br_taken) next_pc = pcPlus4 + br_off;
  end

  // datapath registers; a response landing during reset is simply never latched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      instr      <= '0;
      instrCount <= '0;
    end else begin
      if (state == FETCH && imem.imemReady)
        instr <= imem.imemData;
      if (state == HOLD && instrAccept) begin
        pc         <= next_pc;
        instrCount <= instrCount + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr, pc, pcPlus4, jrTarget;
  logic [5:0]  opcode, funct;
  logic        instrValid, instrAccept, branch, jump, zero, halt;
  logic [31:0] instrCount;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .COUNT_W(32)) dut (
    .clk(clk), .reset(reset), .imem(bus),
    .instr(instr), .opcode(opcode), .funct(funct), .instrValid(instrValid),
    .instrAccept(instrAccept), .branch(branch), .jump(jump), .zero(zero),
    .jrTarget(jrTarget), .halt(halt), .pc(pc), .pcPlus4(pcPlus4),
    .instrCount(instrCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference state: address of the pending instruction, held word, accepted count
  logic [31:0] m_pc, m_word, m_count;

  // next pc straight from the instruction-set rules
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                           input logic br, input logic jp, input logic z,
                                           input logic [31:0] jrt);
    logic [31:0] p4, off;
    int unsigned op, fn;
    p4  = cur + 32'd4;
    op  = word >> 26;
    fn  = word & 32'h3F;
    off = {{16{word[15]}}, word[15:0]} << 2;
    if (op == 0 && fn == 8) return jrt & 32'hFFFF_FFFC;
    if (jp) return (p4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    if (br && ((op == 4 && z) || (op == 5 && !z))) return p4 + off;
    return p4;
  endfunction

  // wait (bounded) for a fetch request, sampling at negedge
  task automatic wait_req();
    int n = 0;
    while (!bus.imemReq && n < 50) begin @(negedge clk); n++; end
    if (!bus.imemReq) begin
      errors++;
      $display("FAIL wait_req: imemReq=%0b after %0d cycles, required 1", bus.imemReq, n);
    end
    checks++;
  endtask

  // memory answers after dly cycles; returns at the first negedge in HOLD
  task automatic supply(input logic [31:0] word, input int dly);
    repeat (dly) @(negedge clk);
    bus.imemReady = 1'b1;
    bus.imemData  = word;
    @(negedge clk);
    bus.imemReady = 1'b0;
    bus.imemData  = $urandom;
    instrAccept   = 1'b0;
    m_word        = word;
  endtask

  // datapath accepts after dly cycles with the given control decisions
  task automatic accept(input logic br, input logic jp, input logic z,
                        input logic [31:0] jrt, input int dly, input logic hlt);
    branch = br; jump = jp; zero = z; jrTarget = jrt;
    repeat (dly) @(negedge clk);
    instrAccept = 1'b1;
    halt        = hlt;
    @(negedge clk);
    instrAccept = 1'b0;
    branch = 1'b0; jump = 1'b0; zero = 1'b0;
    m_pc    = ref_next(m_pc, m_word, br, jp, z, jrt);
    m_count = m_count + 32'd1;
  endtask

  // redirect fetch with a jr; call while in FETCH
  task automatic jump_to(input logic [31:0] target);
    supply(32'h03E0_0008, 0);
    accept(1'b0, 1'b0, 1'b0, target, 0, 1'b0);
    wait_req();
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.imemReady = 1'b0; bus.imemData = '0;
    instrAccept = 0; branch = 0; jump = 0; zero = 0; jrTarget = '0; halt = 0;
    repeat (3) @(negedge clk);
    if (bus.imemReq !== 1'b0) begin errors++; $display("FAIL rst_req: got %0b required 0", bus.imemReq); end checks++;
    if (instrValid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b required 0", instrValid); end checks++;
    if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h required 0", pc); end checks++;
    if (instrCount !== 32'h0) begin errors++; $display("FAIL rst_count: got %0d required 0", instrCount); end checks++;
    if (opcode !== 6'h0 || funct !== 6'h0) begin errors++; $display("FAIL rst_decode: got %h/%h required 0/0", opcode, funct); end checks++;
    reset = 1'b0;
    m_pc = 32'h0; m_count = 32'h0; m_word = 32'h0;
    // first cycle after release is IDLE
    #1;
    if (bus.imemReq !== 1'b0) begin errors++; $display("FAIL idle_req: got %0b required 0", bus.imemReq); end checks++;
    @(negedge clk);
    if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h0) begin
      errors++; $display("FAIL first_fetch: got req=%0b addr=%h required 1/00000000", bus.imemReq, bus.imemAddr);
    end checks++;
  endtask

  task automatic test_sequential();
    repeat (2) begin
      @(negedge clk);
      if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h0) begin
        errors++; $display("FAIL fetch_wait: got req=%0b addr=%h required 1/00000000", bus.imemReq, bus.imemAddr);
      end checks++;
    end
    supply(32'h012A_4020, 0);
    if (instrValid !== 1'b1 || bus.imemReq !== 1'b0) begin
      errors++; $display("FAIL hold_flags: got valid=%0b req=%0b required 1/0", instrValid, bus.imemReq);
    end checks++;
    if (opcode !== 6'h00 || funct !== 6'h20 || instr !== 32'h012A_4020) begin
      errors++; $display("FAIL add_decode: got %h/%h/%h required 00/20/012a4020", opcode, funct, instr);
    end checks++;
    accept(1'b0, 1'b0, 1'b0, 32'h0, 1, 1'b0);
    wait_req();
    if (bus.imemAddr !== 32'h4 || bus.imemAddr !== m_pc) begin
      errors++; $display("FAIL seq_next: got %h required 00000004 (model %h)", bus.imemAddr, m_pc);
    end checks++;
    if (instrCount !== 32'd1) begin errors++; $display("FAIL seq_count: got %0d required 1", instrCount); end checks++;
  endtask

  task automatic test_branch();
    logic [31:0] words [4] = '{32'h1000_0003, 32'h1000_0003, 32'h1400_FFFE, 32'h1400_FFFE};
    logic        zs    [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] exps  [4] = '{32'h20, 32'h14, 32'h0C, 32'h14};
    for (int i = 0; i < 4; i++) begin
      jump_to(32'h10);
      supply(words[i], $urandom_range(0, 2));
      if (pc !== 32'h10 || pcPlus4 !== 32'h14) begin
        errors++; $display("FAIL br_pc[%0d]: got %h/%h required 00000010/00000014", i, pc, pcPlus4);
      end checks++;
      accept(1'b1, 1'b0, zs[i], $urandom, $urandom_range(0, 2), 1'b0);
      wait_req();
      if (bus.imemAddr !== exps[i] || bus.imemAddr !== m_pc) begin
        errors++; $display("FAIL br_next[%0d]: got %h required %h (model %h)", i, bus.imemAddr, exps[i], m_pc);
      end checks++;
    end
  endtask

  task automatic test_jump();
    jump_to(32'h8000_0000);
    supply(32'h0800_0010, 0);
    accept(1'b0, 1'b1, 1'b0, 32'h0, 0, 1'b0);
    wait_req();
    if (bus.imemAddr !== 32'h8000_0040 || bus.imemAddr !== m_pc) begin
      errors++; $display("FAIL j_next: got %h required 80000040 (model %h)", bus.imemAddr, m_pc);
    end checks++;
    supply(32'h03E0_0008, 1);
    accept(1'b1, 1'b1, 1'b1, 32'h103, 0, 1'b0);
    wait_req();
    if (bus.imemAddr !== 32'h100 || bus.imemAddr !== m_pc) begin
      errors++; $display("FAIL jr_next: got %h required 00000100 (model %h)", bus.imemAddr, m_pc);
    end checks++;
  endtask

  task automatic test_halt();
    supply(32'h0000_0000, 0);
    accept(1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (bus.imemReq !== 1'b0 || instrValid !== 1'b0) begin
        errors++; $display("FAIL halt_idle[%0d]: got req=%0b valid=%0b required 0/0", i, bus.imemReq, instrValid);
      end checks++;
      @(negedge clk);
    end
    halt = 1'b0;
    wait_req();
    if (bus.imemAddr !== m_pc || bus.imemAddr !== 32'h104) begin
      errors++; $display("FAIL halt_resume: got %h required 00000104 (model %h)", bus.imemAddr, m_pc);
    end checks++;
    if (instrCount !== m_count) begin errors++; $display("FAIL halt_count: got %0d required %0d", instrCount, m_count); end checks++;
  endtask

  task automatic test_wrap();
    jump_to(32'hFFFF_FFFC);
    supply(32'h0000_0000, 0);
    if (pcPlus4 !== 32'h0) begin errors++; $display("FAIL wrap_p4: got %h required 00000000", pcPlus4); end checks++;
    accept(1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0);
    wait_req();
    if (bus.imemAddr !== 32'h0 || bus.imemAddr !== m_pc) begin
      errors++; $display("FAIL wrap_next: got %h required 00000000 (model %h)", bus.imemAddr, m_pc);
    end checks++;
  endtask

  task automatic test_reset_mid();
    jump_to(32'h40);
    supply(32'hDEAD_BEEF, 0);
    // asynchronous reset in the middle of a HOLD cycle
    #2 reset = 1'b1;
    #1;
    if (instrValid !== 1'b0 || pc !== 32'h0 || instrCount !== 32'h0 || instr !== 32'h0) begin
      errors++; $display("FAIL rst_hold: got valid=%0b pc=%h cnt=%0d instr=%h required 0/0/0/0", instrValid, pc, instrCount, instr);
    end checks++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    // response in flight when reset hits must be dropped
    bus.imemReady = 1'b1; bus.imemData = 32'hCAFE_F00D;
    #2 reset = 1'b1;
    @(negedge clk);
    bus.imemReady = 1'b0;
    reset = 1'b0;
    if (instr !== 32'h0 || instrValid !== 1'b0 || bus.imemReq !== 1'b0) begin
      errors++; $display("FAIL rst_fetch: got instr=%h valid=%0b req=%0b required 0/0/0", instr, instrValid, bus.imemReq);
    end checks++;
    m_pc = 32'h0; m_count = 32'h0;
    wait_req();
    if (bus.imemAddr !== 32'h0) begin errors++; $display("FAIL rst_refetch: got %h required 00000000", bus.imemAddr); end checks++;
  endtask

  task automatic test_random();
    logic [31:0] word;
    logic        h;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 4))
        0: word = {6'd0, 20'($urandom), 6'd8};
        1: word = {6'd2, 26'($urandom)};
        2: word = {6'd4, 26'($urandom)};
        3: word = {6'd5, 26'($urandom)};
        default: word = $urandom;
      endcase
      wait_req();
      if (bus.imemAddr !== m_pc || instrCount !== m_count) begin
        errors++; $display("FAIL rnd_fetch[%0d]: got addr=%h cnt=%0d required %h/%0d", i, bus.imemAddr, instrCount, m_pc, m_count);
      end checks++;
      // controls wiggle while fetching; they must not matter outside HOLD
      branch = 1'($urandom); jump = 1'($urandom); zero = 1'($urandom); jrTarget = $urandom;
      instrAccept = 1'($urandom);
      supply(word, $urandom_range(0, 3));
      if (instrValid !== 1'b1 || pc !== m_pc || opcode !== word[31:26] || funct !== word[5:0]) begin
        errors++; $display("FAIL rnd_hold[%0d]: got v=%0b pc=%h op=%h fn=%h required 1/%h/%h/%h",
                           i, instrValid, pc, opcode, funct, m_pc, word[31:26], word[5:0]);
      end checks++;
      h = ($urandom_range(0, 9) == 0);
      accept(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom_range(0, 2), h);
      if (h) begin
        repeat (2) @(negedge clk);
        if (bus.imemReq !== 1'b0) begin errors++; $display("FAIL rnd_halt[%0d]: got req=%0b required 0", i, bus.imemReq); end checks++;
        halt = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
